// File: rtl/alu_arbiter_if.sv
// Requester, response and ALU-side signal bundle for alu_arbiter.
// slave = arbiter view, master = environment view.
interface alu_arbiter_if #(
    parameter int DATA_W = 32
);
    logic              req0_valid;
    logic              req1_valid;
    logic              req0_ready;
    logic              req1_ready;
    logic [DATA_W-1:0] req0_a;
    logic [DATA_W-1:0] req0_b;
    logic [DATA_W-1:0] req1_a;
    logic [DATA_W-1:0] req1_b;
    logic              req0_risc;
    logic              req1_risc;
    logic [2:0]        req0_funct3;
    logic [2:0]        req1_funct3;
    logic              resp0_valid;
    logic              resp1_valid;
    logic [DATA_W-1:0] resp_data;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic              alu_in_valid;
    logic              alu_risc;
    logic [2:0]        alu_funct3;
    logic [DATA_W-1:0] alu_out;
    logic              alu_out_valid;
    logic              busy;
    logic              err;

    modport slave (
        input  req0_valid, req1_valid,
        input  req0_a, req0_b, req1_a, req1_b,
        input  req0_risc, req1_risc,
        input  req0_funct3, req1_funct3,
        input  alu_out, alu_out_valid,
        output req0_ready, req1_ready,
        output resp0_valid, resp1_valid, resp_data,
        output alu_a, alu_b, alu_in_valid,
        output alu_risc, alu_funct3,
        output busy, err
    );

    modport master (
        output req0_valid, req1_valid,
        output req0_a, req0_b, req1_a, req1_b,
        output req0_risc, req1_risc,
        output req0_funct3, req1_funct3,
        output alu_out, alu_out_valid,
        input  req0_ready, req1_ready,
        input  resp0_valid, resp1_valid, resp_data,
        input  alu_a, alu_b, alu_in_valid,
        input  alu_risc, alu_funct3,
        input  busy, err
    );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: two requesters sharing one 2-cycle pipelined ALU.
// Define ALU_ARB_RR_EN for round-robin; default is fixed priority (port 0).
module alu_arbiter #(
    parameter int DATA_W = 32
) (
    input logic          clk,
    input logic          rst,
    alu_arbiter_if.slave bus
);
    logic              w_both;
    logic              w_pick1;
    logic              w_g0;
    logic              w_g1;
    logic              w_grant;
    logic [DATA_W-1:0] w_a;
    logic [DATA_W-1:0] w_b;
    logic              r_v0;
    logic              r_id0;
    logic              r_v1;
    logic              r_id1;
    logic              r_risc;
    logic [2:0]        r_funct3;
    logic              r_err;
    logic [1:0]        r_quiet;

`ifdef ALU_ARB_RR_EN
    logic r_last;
    assign w_pick1 = ~r_last;
`else
    assign w_pick1 = 1'b0;
`endif

    assign w_both  = bus.req0_valid & bus.req1_valid;
    assign w_g0    = rst & bus.req0_valid & ~(w_both & w_pick1);
    assign w_g1    = rst & bus.req1_valid & ~(w_both & ~w_pick1);
    assign w_grant = w_g0 | w_g1;

    always_comb begin
        w_a = '0;
        w_b = '0;
        if (w_g0) begin
            w_a = bus.req0_a;
            w_b = bus.req0_b;
        end else if (w_g1) begin
            w_a = bus.req1_a;
            w_b = bus.req1_b;
        end
    end

    assign bus.req0_ready   = w_g0;
    assign bus.req1_ready   = w_g1;
    assign bus.alu_a        = w_a;
    assign bus.alu_b        = w_b;
    assign bus.alu_in_valid = w_grant;
    assign bus.alu_risc     = r_risc;
    assign bus.alu_funct3   = r_funct3;
    assign bus.resp_data    = bus.alu_out;
    assign bus.resp0_valid  = rst & bus.alu_out_valid & r_v1 & ~r_id1;
    assign bus.resp1_valid  = rst & bus.alu_out_valid & r_v1 & r_id1;
    assign bus.busy         = rst & (r_v0 | r_v1);
    assign bus.err          = r_err;

    // r_quiet masks results of ops the ALU accepted before a reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_v0     <= 1'b0;
            r_id0    <= 1'b0;
            r_v1     <= 1'b0;
            r_id1    <= 1'b0;
            r_risc   <= 1'b0;
            r_funct3 <= 3'd0;
            r_err    <= 1'b0;
            r_quiet  <= 2'd2;
        end else begin
            r_v0  <= w_grant;
            r_id0 <= w_g1;
            r_v1  <= r_v0;
            r_id1 <= r_id0;
            if (r_quiet != 2'd0)
                r_quiet <= r_quiet - 2'd1;
            if (bus.alu_out_valid && !r_v1 && r_quiet == 2'd0)
                r_err <= 1'b1;
            if (w_grant) begin
                r_risc   <= w_g1 ? bus.req1_risc : bus.req0_risc;
                r_funct3 <= w_g1 ? bus.req1_funct3 : bus.req0_funct3;
            end
        end
    end

`ifdef ALU_ARB_RR_EN
    always_ff @(posedge clk) begin
        if (!rst)
            r_last <= 1'b1;
        else if (w_grant)
            r_last <= w_g1;
    end
`endif
endmodule
